// File: rtl/whack_hit_scorer.sv
// Purpose : player-side scoring for whack-a-mole: hits, misses, false hits, reaction time (ms).
// Latency : button -> score/hit_pulse in 3 cycles; mole_clk/game_in_progress -> outputs in 2 cycles.
// Backpressure: none; free-running, every output is a register updated each cycle.
//
// Ports:
//   clk, rst                 - system clock, synchronous active-high reset
//   game_in_progress         - high while the game FSM is in MOLE_UP/MOLE_DOWN
//   mole_clk                 - high while the mole is up
//   hit_button               - asynchronous (debounced) player button
//   score/misses/false_hits  - saturating per-game counters
//   last_reaction_ms         - reaction of the most recent hit
//   best_reaction_ms         - fastest reaction this game, all-ones when no hit yet
//   hit_pulse/miss_pulse     - one-cycle event strobes
//   dbg_state                - FSM state encoding
module whack_hit_scorer #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int SCORE_W     = 8,
    parameter int REACT_W     = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_in_progress,
    input  logic               mole_clk,
    input  logic               hit_button,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] misses,
    output logic [SCORE_W-1:0] false_hits,
    output logic [REACT_W-1:0] last_reaction_ms,
    output logic [REACT_W-1:0] best_reaction_ms,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic [1:0]         dbg_state
);

    localparam int MS_DIV = CLK_FREQ_HZ / 1000;
    localparam int DIV_W  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MS_DIV - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_UP  = 2'd1,
        ARMED    = 2'd2,
        HIT_DONE = 2'd3
    } state_t;

    state_t             state;
    logic               s1, s2, s3;
    logic               mole_d, mole_q;
    logic               game_d, game_q;
    logic [DIV_W-1:0]   div_cnt;
    logic [REACT_W-1:0] react_cnt;

    logic hit_edge, mole_rise, mole_fall, game_rise;

    // Event detection works on the registered copies so every decision is
    // made from flopped signals only.
    assign hit_edge  = s2 & ~s3;
    assign mole_rise = mole_d & ~mole_q;
    assign mole_fall = ~mole_d & mole_q;
    assign game_rise = game_d & ~game_q;
    assign dbg_state = state;

    function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [REACT_W-1:0] sat_react(input logic [REACT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Input conditioning: 2-flop synchronizer plus an edge flop for the
    // button, one delay stage for the FSM-side levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            mole_d <= 1'b0;
            mole_q <= 1'b0;
            game_d <= 1'b0;
            game_q <= 1'b0;
        end else begin
            s1     <= hit_button;
            s2     <= s1;
            s3     <= s2;
            mole_d <= mole_clk;
            mole_q <= mole_d;
            game_d <= game_in_progress;
            game_q <= game_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            div_cnt          <= '0;
            react_cnt        <= '0;
            score            <= '0;
            misses           <= '0;
            false_hits       <= '0;
            last_reaction_ms <= '0;
            best_reaction_ms <= {REACT_W{1'b1}};
            hit_pulse        <= 1'b0;
            miss_pulse       <= 1'b0;
        end else begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;

            // Millisecond timebase only runs while a mole is armed; entry
            // into ARMED below overrides these updates with a clear.
            if (state == ARMED) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt   <= '0;
                    react_cnt <= sat_react(react_cnt);
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end

            if (!game_d) begin
                // Game ended (or not started): abandon any armed mole silently.
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (game_rise) begin
                            score            <= '0;
                            misses           <= '0;
                            false_hits       <= '0;
                            last_reaction_ms <= '0;
                            best_reaction_ms <= {REACT_W{1'b1}};
                            div_cnt          <= '0;
                            react_cnt        <= '0;
                            // Mole may already be up when the game starts.
                            state <= mole_d ? ARMED : WAIT_UP;
                        end
                    end
                    WAIT_UP: begin
                        if (mole_rise) begin
                            div_cnt   <= '0;
                            react_cnt <= '0;
                            if (hit_edge) begin
                                // Press coincident with the rise: zero-ms hit.
                                state            <= HIT_DONE;
                                score            <= sat_score(score);
                                hit_pulse        <= 1'b1;
                                last_reaction_ms <= '0;
                                best_reaction_ms <= '0;
                            end else begin
                                state <= ARMED;
                            end
                        end else if (hit_edge) begin
                            false_hits <= sat_score(false_hits);
                        end
                    end
                    ARMED: begin
                        if (mole_fall) begin
                            // Window closed first; a simultaneous press is late.
                            state      <= WAIT_UP;
                            misses     <= sat_score(misses);
                            miss_pulse <= 1'b1;
                            if (hit_edge) begin
                                false_hits <= sat_score(false_hits);
                            end
                        end else if (hit_edge) begin
                            state            <= HIT_DONE;
                            score            <= sat_score(score);
                            hit_pulse        <= 1'b1;
                            last_reaction_ms <= react_cnt;
                            if (react_cnt < best_reaction_ms) begin
                                best_reaction_ms <= react_cnt;
                            end
                        end
                    end
                    HIT_DONE: begin
                        if (hit_edge) begin
                            false_hits <= sat_score(false_hits);
                        end
                        if (mole_fall) begin
                            state <= WAIT_UP;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
